grover_invert_mean_seq: RTL and testbench

GROVER_INVERT_MEAN_SEQ -- requirements
Module: grover_invert_mean_seq

---
 rtl/grover_pkg.sv | 18 +
 rtl/grover_sample_buf.sv | 38 +++
 rtl/grover_invert_mean_seq.sv | 183 ++++++++++++++++++
 tb/tb_grover_invert_mean_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grover_pkg.sv
// Shared definitions for the grover_invert_mean_seq block.
// Contents:
//   state_t   - frame sequencer states (LOAD, CALC, EMIT)
//   acc_width - width of the running-sum accumulator (DATA_W + NUM_BIT),
//               wide enough to add N = 2**NUM_BIT signed samples without overflow
package grover_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic int acc_width(input int data_w, input int num_bit);
    return data_w + num_bit;
  endfunction

endpackage

// File: rtl/grover_sample_buf.sv
// Sample buffer for one frame of grover_invert_mean_seq.
// One synchronous write port and one combinational read port; the array is
// intentionally not reset (a frame is always fully rewritten before it is read).
// Ports:
//   clk     - write clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (combinational)
module grover_sample_buf
  import grover_pkg::*;
#(
  parameter int NUM_BIT = 3,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [NUM_BIT-1:0] i_waddr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [NUM_BIT-1:0] i_raddr,
  output logic [DATA_W-1:0]  o_rdata
);

  localparam int N = 2 ** NUM_BIT;

  logic [DATA_W-1:0] r_mem [N];

  // Store an accepted sample.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/grover_invert_mean_seq.sv
// grover_invert_mean_seq: "inversion about the mean" over frames of N = 2**NUM_BIT
// signed samples. A frame is loaded, 2*mean is computed in one cycle, then every
// sample x is emitted as 2*mean - x in arrival order. Frames never overlap.
//
// Optional feature: define GROVER_INVERT_MEAN_SAT_EN to saturate out_data to the
// DATA_W signed range; otherwise the low DATA_W bits are emitted (wrap).
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (drops any partial frame)
//   in_valid   - input sample valid
//   in_ready   - input accepted this cycle (LOAD only)
//   in_data    - signed input sample
//   out_valid  - output sample valid (EMIT only)
//   out_ready  - downstream accepts output
//   out_data   - signed 2*mean - x, zero when out_valid is low
//   out_last   - last output of the frame
//   busy       - frame in progress (not LOAD, or samples already loaded)
module grover_invert_mean_seq
  import grover_pkg::*;
#(
  parameter int NUM_BIT = 3,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int ACC_W = acc_width(DATA_W, NUM_BIT);
  localparam int TM_W  = DATA_W + 2;
  localparam int N     = 2 ** NUM_BIT;
  localparam logic [NUM_BIT-1:0] LAST_IDX = NUM_BIT'(N - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic signed [ACC_W-1:0]   r_sum;
  logic signed [TM_W-1:0]    r_two_mean;
  logic        [NUM_BIT-1:0] r_wr_idx;
  logic        [NUM_BIT-1:0] r_rd_idx;

  logic                      w_in_fire;
  logic                      w_out_fire;
  logic                      w_frame_done;
  logic        [DATA_W-1:0]  w_rd_data;
  logic signed [ACC_W-1:0]   w_in_ext;
  logic signed [ACC_W+1:0]   w_sum_wide;
  logic signed [TM_W-1:0]    w_rd_ext;
  logic signed [TM_W-1:0]    w_diff;
  logic        [DATA_W-1:0]  w_narrow;

`ifdef GROVER_INVERT_MEAN_SAT_EN
  localparam logic signed [TM_W-1:0] SAT_MAX = TM_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [TM_W-1:0] SAT_MIN = TM_W'(-(2 ** (DATA_W - 1)));

  function automatic logic [DATA_W-1:0] sat_narrow(input logic signed [TM_W-1:0] v);
    logic [DATA_W-1:0] res;
    if (v > SAT_MAX) begin
      res = DATA_W'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      res = DATA_W'(SAT_MIN);
    end else begin
      res = DATA_W'(v);
    end
    return res;
  endfunction
`endif

  // Handshake decode; in_ready/out_valid are pure state decodes.
  assign in_ready     = (r_state == LOAD);
  assign out_valid    = (r_state == EMIT);
  assign w_in_fire    = in_valid && in_ready;
  assign w_out_fire   = out_valid && out_ready;
  assign w_frame_done = w_out_fire && (r_rd_idx == LAST_IDX);

  assign w_in_ext   = {{NUM_BIT{in_data[DATA_W-1]}}, in_data};
  // Two guard bits so the floor shift also works when NUM_BIT = 1 (ACC_W < TM_W).
  assign w_sum_wide = {{2{r_sum[ACC_W-1]}}, r_sum};
  assign w_rd_ext   = {{2{w_rd_data[DATA_W-1]}}, w_rd_data};
  assign w_diff     = r_two_mean - w_rd_ext;

`ifdef GROVER_INVERT_MEAN_SAT_EN
  assign w_narrow = sat_narrow(w_diff);
`else
  assign w_narrow = DATA_W'(w_diff);
`endif

  // The buffer is only read in EMIT, where rd_idx cannot change while stalled,
  // so out_data and out_last hold under back-pressure without extra registers.
  assign out_data = out_valid ? w_narrow : {DATA_W{1'b0}};
  assign out_last = out_valid && (r_rd_idx == LAST_IDX);
  assign busy     = (r_state != LOAD) || (r_wr_idx != {NUM_BIT{1'b0}});

  grover_sample_buf #(
    .NUM_BIT (NUM_BIT),
    .DATA_W  (DATA_W)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_waddr (r_wr_idx),
    .i_wdata (in_data),
    .i_raddr (r_rd_idx),
    .o_rdata (w_rd_data)
  );

  // Frame sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame sequencer next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD: begin
        if (w_in_fire && (r_wr_idx == LAST_IDX)) begin
          w_state_nxt = CALC;
        end else begin
          w_state_nxt = LOAD;
        end
      end
      CALC: begin
        w_state_nxt = EMIT;
      end
      EMIT: begin
        if (w_frame_done) begin
          w_state_nxt = LOAD;
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // Running sum and write index; both return to zero when a frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum    <= {ACC_W{1'b0}};
      r_wr_idx <= {NUM_BIT{1'b0}};
    end else if (w_frame_done) begin
      r_sum    <= {ACC_W{1'b0}};
      r_wr_idx <= {NUM_BIT{1'b0}};
    end else if (w_in_fire) begin
      r_sum    <= r_sum + w_in_ext;
      r_wr_idx <= r_wr_idx + NUM_BIT'(1);
    end
  end

  // 2*mean = floor(sum / 2**(NUM_BIT-1)); arithmetic shift gives floor rounding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_two_mean <= {TM_W{1'b0}};
    end else if (r_state == CALC) begin
      r_two_mean <= TM_W'(w_sum_wide >>> (NUM_BIT - 1));
    end
  end

  // Read index advances on each accepted output and wraps at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_idx <= {NUM_BIT{1'b0}};
    end else if (w_frame_done) begin
      r_rd_idx <= {NUM_BIT{1'b0}};
    end else if (w_out_fire) begin
      r_rd_idx <= r_rd_idx + NUM_BIT'(1);
    end
  end

endmodule

// File: tb/tb_grover_invert_mean_seq.sv
// Self-checking bench for grover_invert_mean_seq (NUM_BIT=3, DATA_W=8).
module tb_grover_invert_mean_seq;

  localparam int NUM_BIT = 3;
  localparam int DATA_W  = 8;
  localparam int N       = 8;

  typedef int frame_t [N];

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  grover_invert_mean_seq #(.NUM_BIT(NUM_BIT), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int fit_out(input int v);
    int m;
`ifdef GROVER_INVERT_MEAN_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    m = ((v % 256) + 256) % 256;
    if (m >= 128) m = m - 256;
    return m;
`endif
  endfunction

  task automatic model_frame(input frame_t s, output frame_t e);
    int sum;
    int tm;
    sum = 0;
    foreach (s[i]) sum += s[i];
    tm = floor_div(2 * sum, N);
    foreach (s[i]) e[i] = fit_out(tm - s[i]);
  endtask

  task automatic rand_frame(output frame_t s);
    foreach (s[i]) s[i] = int'($urandom_range(255)) - 128;
  endtask

  // ---------------- drivers ----------------
  task automatic send_frame(input frame_t s, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(2)) begin
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(s[i]);
      n_total++;
      if (in_ready !== 1'b1) $display("FAIL load_ready i=%0d got=%b exp=1", i, in_ready);
      else n_pass++;
      n_total++;
      if (busy !== (i != 0)) $display("FAIL load_busy i=%0d got=%b exp=%b", i, busy, (i != 0));
      else n_pass++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL calc_cycle got valid=%b ready=%b busy=%b exp 0 0 1", out_valid, in_ready, busy);
    else n_pass++;
  endtask

  task automatic recv_frame(input frame_t e, input int stall_pct, input int j0, input int j1,
                            input bit chk_lat);
    int  j;
    int  cyc;
    logic [DATA_W-1:0] exp8;
    j   = j0;
    cyc = 0;
    while (j < j1 && cyc < 200) begin
      @(negedge clk);
      if (chk_lat && cyc == 0) begin
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL latency got out_valid=%b exp=1", out_valid);
        else n_pass++;
      end
      cyc++;
      if (out_valid === 1'b1) begin
        out_ready = (int'($urandom_range(99)) >= stall_pct);
        if (out_ready) begin
          exp8 = DATA_W'(e[j]);
          n_total++;
          if (out_data !== exp8) $display("FAIL out_data j=%0d got=%0d exp=%0d", j, $signed(out_data), e[j]);
          else n_pass++;
          n_total++;
          if (out_last !== (j == N - 1)) $display("FAIL out_last j=%0d got=%b exp=%b", j, out_last, (j == N - 1));
          else n_pass++;
          j++;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
    if (j < j1) begin
      n_total++;
      $display("FAIL recv_timeout got=%0d outputs exp=%0d", j, j1);
    end
    if (j1 == N) begin
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL frame_end got valid=%b data=%0d busy=%b ready=%b exp 0 0 0 1",
                 out_valid, out_data, busy, in_ready);
      else n_pass++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs got valid=%b data=%0d last=%b busy=%b exp all 0",
               out_valid, out_data, out_last, busy);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready);
    else n_pass++;
  endtask

  task automatic test_const_frame();
    frame_t s, e;
    foreach (s[i]) s[i] = 10;
    model_frame(s, e);
    send_frame(s, 1'b0);
    recv_frame(e, 0, 0, N, 1'b1);
  endtask

  task automatic test_directed();
    frame_t s, e;
    s = '{10, 10, -10, 10, 10, 10, 10, 10};
    model_frame(s, e); send_frame(s, 1'b0); recv_frame(e, 0, 0, N, 1'b1);
    s = '{-1, 0, 0, 0, 0, 0, 0, 0};
    model_frame(s, e); send_frame(s, 1'b0); recv_frame(e, 0, 0, N, 1'b1);
    s = '{-128, 127, 127, 127, 127, 127, 127, 127};
    model_frame(s, e); send_frame(s, 1'b0); recv_frame(e, 0, 0, N, 1'b1);
    s = '{127, -128, -128, -128, -128, -128, -128, -128};
    model_frame(s, e); send_frame(s, 1'b0); recv_frame(e, 0, 0, N, 1'b1);
  endtask

  task automatic test_random();
    frame_t s, e;
    for (int f = 0; f < 12; f++) begin
      rand_frame(s);
      model_frame(s, e);
      send_frame(s, 1'b1);
      recv_frame(e, 40, 0, N, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    frame_t s, e;
    logic [DATA_W-1:0] exp8;
    rand_frame(s);
    model_frame(s, e);
    send_frame(s, 1'b0);
    exp8 = DATA_W'(e[0]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== exp8 || out_last !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL stall_first k=%0d got valid=%b data=%0d last=%b ready=%b exp 1 %0d 0 0",
                 k, out_valid, $signed(out_data), out_last, in_ready, e[0]);
      else n_pass++;
    end
    in_valid = 1'b0;
    recv_frame(e, 0, 0, N - 1, 1'b0);
    exp8 = DATA_W'(e[N-1]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b1 || out_data !== exp8 || out_last !== 1'b1)
        $display("FAIL stall_last k=%0d got valid=%b data=%0d last=%b exp 1 %0d 1",
                 k, out_valid, $signed(out_data), out_last, e[N-1]);
      else n_pass++;
    end
    recv_frame(e, 0, N - 1, N, 1'b0);
    rand_frame(s);
    model_frame(s, e);
    send_frame(s, 1'b0);
    recv_frame(e, 0, 0, N, 1'b1);
  endtask

  task automatic test_reset_mid_emit();
    frame_t s, e;
    rand_frame(s);
    model_frame(s, e);
    send_frame(s, 1'b0);
    recv_frame(e, 0, 0, 2, 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL pre_abort_valid got=%b exp=1", out_valid);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort got valid=%b data=%0d last=%b busy=%b ready=%b exp 0 0 0 0 1",
               out_valid, out_data, out_last, busy, in_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    rand_frame(s);
    model_frame(s, e);
    send_frame(s, 1'b0);
    recv_frame(e, 0, 0, N, 1'b1);
  endtask

  task automatic test_back_to_back();
    frame_t s, e;
    for (int f = 0; f < 3; f++) begin
      rand_frame(s);
      model_frame(s, e);
      send_frame(s, 1'b0);
      recv_frame(e, 0, 0, N, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_const_frame();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_emit();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
